// File: rtl/fact_accel_pkg.sv
// Shared definitions for the factorial accelerator: register word indices,
// control-FSM states and the bit positions inside the control/status words.
package fact_accel_pkg;

  localparam int IDX_W = 6;

  // Word indices (byte address bits [8:3])
  localparam logic [IDX_W-1:0] REG_OPSTART  = 6'd0;
  localparam logic [IDX_W-1:0] REG_OPCLEAR  = 6'd1;
  localparam logic [IDX_W-1:0] REG_OPDONE   = 6'd2;
  localparam logic [IDX_W-1:0] REG_INTREN   = 6'd3;
  localparam logic [IDX_W-1:0] REG_OPERAND  = 6'd4;
  localparam logic [IDX_W-1:0] REG_RESULT_H = 6'd5;
  localparam logic [IDX_W-1:0] REG_RESULT_L = 6'd6;
  localparam logic [IDX_W-1:0] REG_MODE     = 6'd7;
  localparam logic [IDX_W-1:0] REG_STATUS   = 6'd8;
  localparam logic [IDX_W-1:0] REG_CYCLES   = 6'd9;

  // Bit positions
  localparam int OPDONE_DONE_BIT = 0;
  localparam int OPDONE_BUSY_BIT = 1;
  localparam int MODE_DFACT_BIT  = 0;  // 0 = n!, 1 = n!!
  localparam int STATUS_OVF_BIT  = 0;
  localparam int INTREN_EN_BIT   = 0;

  localparam logic MODE_FACT  = 1'b0;
  localparam logic MODE_DFACT = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: (2*DW) x DW -> 3*DW in exactly DW cycles.
// done_o is raised during the last iteration cycle and p_o then carries the
// finished product (the final partial sum is folded in combinationally), so
// the caller can capture the result on the same edge the iteration ends.
module mul_iter #(
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2*DW-1:0] a_i,
  input  logic [DW-1:0]   b_i,
  output logic            done_o,
  output logic [3*DW-1:0] p_o
);

  localparam int CNT_W = $clog2(DW);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3*DW-1:0]  a_q;
  logic [DW-1:0]    b_q;
  logic [3*DW-1:0]  p_q;
  logic [3*DW-1:0]  step_sum;
  logic             last_step;

  // Partial sum including the current multiplier bit
  always_comb begin
    step_sum  = p_q + (b_q[0] ? a_q : '0);
    last_step = busy_q && (cnt_q == CNT_W'(DW - 1));
  end

  assign done_o = last_step;
  assign p_o    = step_sum;

  // Iteration state: load on start, then one shift-add per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      a_q    <= {{DW{1'b0}}, a_i};
      b_q    <= b_i;
      p_q    <= '0;
    end else if (busy_q) begin
      p_q   <= step_sum;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fact_accel.sv
// Factorial / double-factorial accelerator with a simple select/write bus.
// The control FSM walks the operand down to 1, feeding one multiply per step
// into mul_iter; the accumulator keeps 2*DW bits and overflow is sticky.
module fact_accel
  import fact_accel_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          interrupt
);

  localparam logic [2*DW-1:0] ACC_ONE = (2*DW)'(1);

  state_e            state_q, state_d;
  logic [DW-1:0]     counter_q, counter_d;
  logic [2*DW-1:0]   acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     cycles_q, cycles_d;

  logic              intren_q;
  logic              mode_q;
  logic [DW-1:0]     operand_q;

  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic              start_req;
  logic              clear_req;
  logic              cfg_open;
  logic              st_done;
  logic              st_busy;
  logic [2*DW-1:0]   result;

  logic              mul_start;
  logic              mul_done;
  logic [3*DW-1:0]   mul_p;

  // Only bits [8:3] decode a register; the rest of the address is ignored
  logic              unused_addr;
  assign unused_addr = ^s_addr;

  assign idx       = s_addr[8:3];
  assign wr_en     = s_sel && s_wr;
  assign start_req = wr_en && (idx == REG_OPSTART) && s_din[0];
  assign clear_req = wr_en && (idx == REG_OPCLEAR) && s_din[0];
  assign cfg_open  = (state_q == IDLE);
  assign st_done   = (state_q == DONE);
  assign st_busy   = (state_q == LOAD) || (state_q == CHECK) || (state_q == MUL);
  assign result    = st_done ? acc_q : ACC_ONE;
  assign interrupt = intren_q && st_done;

  mul_iter #(.DW(DW)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (mul_start),
    .a_i     (acc_q),
    .b_i     (counter_q),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // Configuration registers; operand/mode are frozen outside IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intren_q  <= 1'b0;
      mode_q    <= MODE_FACT;
      operand_q <= '0;
    end else begin
      if (wr_en && (idx == REG_INTREN)) begin
        intren_q <= s_din[INTREN_EN_BIT];
      end
      if (wr_en && cfg_open && (idx == REG_OPERAND)) begin
        operand_q <= s_din;
      end
      if (wr_en && cfg_open && (idx == REG_MODE)) begin
        mode_q <= s_din[MODE_DFACT_BIT];
      end
    end
  end

  // Control FSM and datapath state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      acc_q     <= ACC_ONE;
      ovf_q     <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cycles_q  <= cycles_d;
    end
  end

  // Next-state logic; a clear request overrides everything else
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cycles_d  = cycles_q;
    mul_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        counter_d = operand_q;
        acc_d     = ACC_ONE;
        ovf_d     = 1'b0;
        cycles_d  = DW'(1);  // this LOAD cycle is the first counted one
        state_d   = CHECK;
      end
      CHECK: begin
        cycles_d = cycles_q + DW'(1);
        if (counter_q > DW'(1)) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end else begin
          state_d = DONE;
        end
      end
      MUL: begin
        cycles_d = cycles_q + DW'(1);
        if (mul_done) begin
          acc_d = mul_p[2*DW-1:0];
          if (|mul_p[3*DW-1:2*DW]) begin
            ovf_d = 1'b1;
          end
          if (mode_q == MODE_DFACT) begin
            counter_d = (counter_q > DW'(1)) ? counter_q - DW'(2) : '0;
          end else begin
            counter_d = counter_q - DW'(1);
          end
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_req) begin
      state_d   = IDLE;
      acc_d     = ACC_ONE;
      ovf_d     = 1'b0;
      cycles_d  = '0;
      mul_start = 1'b0;
    end
  end

  // Read mux: registered state only, zero when not a read of a readable word
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (idx)
        REG_OPDONE: begin
          s_dout[OPDONE_DONE_BIT] = st_done;
          s_dout[OPDONE_BUSY_BIT] = st_busy;
        end
        REG_INTREN:   s_dout[INTREN_EN_BIT]  = intren_q;
        REG_OPERAND:  s_dout                 = operand_q;
        REG_RESULT_H: s_dout                 = result[2*DW-1:DW];
        REG_RESULT_L: s_dout                 = result[DW-1:0];
        REG_MODE:     s_dout[MODE_DFACT_BIT] = mode_q;
        REG_STATUS:   s_dout[STATUS_OVF_BIT] = ovf_q;
        REG_CYCLES:   s_dout                 = cycles_q;
        default:      s_dout                 = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_accel.sv
// Bench for fact_accel: directed cases plus randomized operands compared
// against a plain-arithmetic factorial model.
module tb_fact_accel;

  localparam int DW = 64;
  localparam int AW = 16;

  localparam logic [5:0] I_OPSTART  = 6'd0;
  localparam logic [5:0] I_OPCLEAR  = 6'd1;
  localparam logic [5:0] I_OPDONE   = 6'd2;
  localparam logic [5:0] I_INTREN   = 6'd3;
  localparam logic [5:0] I_OPERAND  = 6'd4;
  localparam logic [5:0] I_RESULT_H = 6'd5;
  localparam logic [5:0] I_RESULT_L = 6'd6;
  localparam logic [5:0] I_MODE     = 6'd7;
  localparam logic [5:0] I_STATUS   = 6'd8;
  localparam logic [5:0] I_CYCLES   = 6'd9;

  logic          clk;
  logic          reset_n;
  logic          s_sel;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          interrupt;

  int tests_run;
  int tests_failed;

  fact_accel #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [5:0] idx);
    logic [AW-1:0] a;
    a = '0;
    a[8:3] = idx;
    return a;
  endfunction

  task automatic bus_wr(input logic [5:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = addr_of(idx);
    s_din  = data;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
    s_wr  = 1'b0;
    s_din = '0;
  endtask

  task automatic bus_rd(input logic [5:0] idx, output logic [DW-1:0] data);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = addr_of(idx);
    #1;
    data  = s_dout;
    s_sel = 1'b0;
  endtask

  // Reference: repeated multiply by n, n-1 (or n-2), ... with 192-bit products
  function automatic void ref_model(input logic [DW-1:0] n_in, input bit dfact,
                                    output logic [127:0] res, output bit ovf, output int k);
    logic [191:0] prod;
    logic [127:0] acc;
    logic [63:0]  n;
    acc = 128'd1;
    n   = n_in;
    ovf = 1'b0;
    k   = 0;
    while (n > 64'd1) begin
      prod = {64'd0, acc} * {128'd0, n};
      if (prod[191:128] != 64'd0) ovf = 1'b1;
      acc = prod[127:0];
      n   = dfact ? ((n >= 64'd2) ? n - 64'd2 : 64'd0) : n - 64'd1;
      k++;
    end
    res = acc;
  endfunction

  // Count busy cycles from the start write until done is seen
  task automatic wait_done(output int lat, output bit seen, output logic irq, output logic [DW-1:0] opd);
    logic [DW-1:0] d;
    lat  = 0;
    seen = 1'b0;
    irq  = 1'b0;
    opd  = '0;
    for (int i = 0; i < 20000; i++) begin
      bus_rd(I_OPDONE, d);
      if (d[0]) begin
        seen = 1'b1;
        irq  = interrupt;
        opd  = d;
        break;
      end
      if (d[1]) lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] n, input bit dfact, input bit ien);
    logic [DW-1:0] d, rh, rl, st, cy;
    logic [127:0]  exp_res;
    bit            exp_ovf, seen;
    int            k, lat;
    logic          irq;

    bus_wr(I_OPCLEAR, 64'd1);
    bus_rd(I_OPDONE, d);
    check({tag, "_clr_opdone"}, 128'(d), 128'd0);
    bus_rd(I_STATUS, d);
    check({tag, "_clr_status"}, 128'(d), 128'd0);
    bus_wr(I_INTREN, 64'(ien));
    bus_wr(I_MODE, 64'(dfact));
    bus_wr(I_OPERAND, n);
    ref_model(n, dfact, exp_res, exp_ovf, k);
    bus_wr(I_OPSTART, 64'd1);
    wait_done(lat, seen, irq, d);
    check({tag, "_done_seen"}, 128'(seen), 128'd1);
    check({tag, "_opdone"}, 128'(d), 128'd1);
    check({tag, "_latency"}, 128'(lat), 128'(2 + k * (DW + 1)));
    check({tag, "_irq"}, 128'(irq), 128'(ien));
    bus_rd(I_RESULT_H, rh);
    bus_rd(I_RESULT_L, rl);
    bus_rd(I_STATUS, st);
    bus_rd(I_CYCLES, cy);
    check({tag, "_result"}, {rh, rl}, exp_res);
    check({tag, "_status"}, 128'(st), 128'(exp_ovf));
    check({tag, "_cycles"}, 128'(cy), 128'(2 + k * (DW + 1)));
    $display("[TB] %s n=%0d mode=%0d result=%0h ovf=%0d cycles=%0d", tag, n, dfact, {rh, rl}, st[0], cy);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] rn;
    bit            seen;
    int            lat;
    logic          irq;

    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    s_sel   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    bus_rd(I_OPDONE, d);   check("rst_opdone", 128'(d), 128'd0);
    bus_rd(I_INTREN, d);   check("rst_intren", 128'(d), 128'd0);
    bus_rd(I_OPERAND, d);  check("rst_operand", 128'(d), 128'd0);
    bus_rd(I_MODE, d);     check("rst_mode", 128'(d), 128'd0);
    bus_rd(I_STATUS, d);   check("rst_status", 128'(d), 128'd0);
    bus_rd(I_CYCLES, d);   check("rst_cycles", 128'(d), 128'd0);
    bus_rd(I_RESULT_H, d); check("rst_result_h", 128'(d), 128'd0);
    bus_rd(I_RESULT_L, d); check("rst_result_l", 128'(d), 128'd1);
    check("rst_irq", 128'(interrupt), 128'd0);
    $display("[TB] reset state read back");

    // Read-data gating
    bus_rd(6'd12, d);      check("rd_unmapped", 128'(d), 128'd0);
    bus_rd(I_OPSTART, d);  check("rd_opstart", 128'(d), 128'd0);
    bus_rd(I_OPCLEAR, d);  check("rd_opclear", 128'(d), 128'd0);
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0; s_addr = addr_of(I_RESULT_L);
    #1 check("rd_nosel", 128'(s_dout), 128'd0);
    s_sel = 1'b1; s_wr = 1'b1; s_din = 64'd0;
    #1 check("rd_during_wr", 128'(s_dout), 128'd0);
    s_sel = 1'b0; s_wr = 1'b0;
    $display("[TB] read gating checked");

    // Directed operations
    run_op("f5", 64'd5, 1'b0, 1'b0);
    run_op("f0", 64'd0, 1'b0, 1'b0);
    run_op("f1", 64'd1, 1'b0, 1'b0);
    run_op("df5", 64'd5, 1'b1, 1'b0);
    run_op("f35", 64'd35, 1'b0, 1'b0);
    run_op("f34", 64'd34, 1'b0, 1'b0);
    run_op("irq3", 64'd3, 1'b0, 1'b1);

    // Writes in DONE are ignored; clear drops the interrupt
    bus_wr(I_OPERAND, 64'd9);
    bus_rd(I_OPERAND, d);  check("done_operand_hold", 128'(d), 128'd3);
    bus_wr(I_OPSTART, 64'd1);
    repeat (3) @(posedge clk);
    bus_rd(I_OPDONE, d);   check("done_start_ignored", 128'(d), 128'd1);
    bus_rd(I_CYCLES, d);   check("done_cycles_frozen", 128'(d), 128'd132);
    bus_wr(I_OPCLEAR, 64'd1);
    bus_rd(I_RESULT_L, d); check("clr_result_l", 128'(d), 128'd1);
    check("clr_irq", 128'(interrupt), 128'd0);
    bus_rd(I_CYCLES, d);   check("clr_cycles", 128'(d), 128'd0);
    $display("[TB] done-state write protection and clear checked");

    // Abort mid-operation, then a fresh run
    bus_wr(I_INTREN, 64'd0);
    bus_wr(I_MODE, 64'd0);
    bus_wr(I_OPERAND, 64'd20);
    bus_wr(I_OPSTART, 64'd1);
    bus_wr(I_OPERAND, 64'd9);
    bus_rd(I_OPERAND, d);  check("busy_operand_hold", 128'(d), 128'd20);
    bus_rd(I_OPDONE, d);   check("busy_flag", 128'(d), 128'd2);
    repeat (34) @(posedge clk);
    bus_wr(I_OPCLEAR, 64'd1);
    bus_rd(I_OPDONE, d);   check("abort_opdone", 128'(d), 128'd0);
    bus_rd(I_CYCLES, d);   check("abort_cycles", 128'(d), 128'd0);
    bus_rd(I_RESULT_L, d); check("abort_result_l", 128'(d), 128'd1);
    bus_wr(I_OPERAND, 64'd4);
    bus_wr(I_OPSTART, 64'd1);
    wait_done(lat, seen, irq, d);
    check("after_abort_done", 128'(seen), 128'd1);
    check("after_abort_latency", 128'(lat), 128'(2 + 3 * (DW + 1)));
    bus_rd(I_RESULT_L, d); check("after_abort_result", 128'(d), 128'd24);
    $display("[TB] abort at cycle 40 then n=4 result=%0d", d);

    // Reset in the middle of an operation
    bus_wr(I_OPCLEAR, 64'd1);
    bus_wr(I_INTREN, 64'd1);
    bus_wr(I_OPERAND, 64'd6);
    bus_wr(I_OPSTART, 64'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check("midrst_irq", 128'(interrupt), 128'd0);
    bus_rd(I_OPDONE, d);   check("midrst_opdone", 128'(d), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(I_OPERAND, d);  check("midrst_operand", 128'(d), 128'd0);
    bus_rd(I_INTREN, d);   check("midrst_intren", 128'(d), 128'd0);
    repeat (500) @(posedge clk);
    bus_rd(I_OPDONE, d);   check("midrst_no_done", 128'(d), 128'd0);
    check("midrst_no_irq", 128'(interrupt), 128'd0);
    $display("[TB] reset during operation discarded the computation");

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      rn = 64'($urandom_range(0, 36));
      run_op($sformatf("rnd%0d", i), rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 Parameter DW, default 64, operand and bus data width; result width is 2*DW; legal DW is 16..64, multiple of 8.
REQ-002 Parameter AW, default 16, bus address width.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 s_sel  input  1  slave select.
REQ-006 s_wr  input  1  1=write, 0=read.
REQ-007 s_addr  input  AW  byte address; word index is s_addr[8:3].
REQ-008 s_din  input  DW  write data.
REQ-009 s_dout  output  DW  read data, combinational.
REQ-010 interrupt  output  1  INTREN[0] AND OPDONE[0].

Function
REQ-011 The register map SHALL be as follows (word index, access, name):
- 0 W OPSTART
- 1 W OPCLEAR
- 2 R OPDONE: bit0 done, bit1 busy
- 3 RW INTREN
- 4 RW OPERAND
- 5 R RESULT_H
- 6 R RESULT_L
- 7 RW MODE: bit0, 0=n!, 1=n!!
- 8 R STATUS: bit0 overflow
- 9 R CYCLES
REQ-012 s_dout SHALL be 0 when s_sel=0, when s_wr=1, or for an unmapped or write-only index.
REQ-013 The FSM SHALL have states IDLE, LOAD, CHECK, MUL and DONE.
REQ-014 IDLE->LOAD SHALL occur in the cycle after an OPSTART write with s_din[0]=1.
REQ-015 LOAD (1 cycle) SHALL set counter=OPERAND, acc=1, overflow=0, CYCLES=0.
REQ-016 CHECK (1 cycle) SHALL go to MUL when counter>1, else to DONE.
REQ-017 MUL SHALL last exactly DW cycles, computing acc*counter; it SHALL then set counter to counter-1 (MODE0=0) or counter-2 (MODE0=1, saturating at 0) and return to CHECK.
REQ-018 The product width SHALL be 3*DW; acc SHALL keep the low 2*DW bits, and overflow SHALL be set sticky if the upper DW bits are nonzero.
REQ-019 DONE SHALL set OPDONE[0]=1 and expose acc as RESULT_H/RESULT_L; OPDONE[1]=1 in LOAD, CHECK and MUL only.
REQ-020 Busy-cycle latency SHALL be 2 + k*(DW+1), where k is the multiply count; CYCLES SHALL increment each cycle in LOAD, CHECK and MUL and freeze in DONE.
REQ-021 Writes to OPERAND, MODE and OPSTART while busy or in DONE SHALL be ignored; INTREN is writable at any time.
REQ-022 An OPCLEAR write with s_din[0]=1 in any state SHALL abort to IDLE next cycle and clear OPDONE, STATUS and CYCLES, with RESULT_H=0 and RESULT_L=1.
REQ-023 OPCLEAR SHALL take priority over OPSTART in the same cycle.
REQ-024 OPERAND 0 or 1 SHALL give result 1 with k=0 and latency 2.
REQ-025 OPSTART and OPCLEAR SHALL be self-clearing pulses, never read back.

Reset
REQ-026 On reset_n=0, the FSM SHALL go to IDLE and INTREN, OPERAND, MODE, OPDONE, STATUS and CYCLES SHALL be 0.
REQ-027 On reset, RESULT_H SHALL be 0, RESULT_L SHALL be 1 and interrupt SHALL be 0.
REQ-028 Reset mid-operation SHALL discard the computation with no completion or interrupt.

Structure
REQ-029 Package fact_accel_pkg SHALL hold the register index constants, the FSM state enum and the MODE bit definitions.
REQ-030 The multiply SHALL be a sub-module mul_iter: a radix-2 shift-add 2*DW x DW multiplier with start/done ports, DW cycles per multiply and a 3*DW result.
REQ-031 No combinational path from s_din to s_dout SHALL exist.

Verification
REQ-032 DW=64: OPERAND=5, MODE=0, start -> RESULT_L=120, RESULT_H=0, OPDONE=1, CYCLES=262, STATUS=0.
REQ-033 OPERAND=0 and OPERAND=1 -> RESULT_L=1, CYCLES=2.
REQ-034 OPERAND=5, MODE=1 -> RESULT_L=15, CYCLES=2+2*65=132.
REQ-035 OPERAND=35, MODE=0 -> STATUS[0]=1; OPERAND=34 -> STATUS[0]=0 and RESULT_H:RESULT_L equal 34! exactly.
REQ-036 INTREN=1, OPERAND=3 -> interrupt rises at DONE with RESULT_L=6; OPCLEAR -> interrupt=0, RESULT_L=1.
REQ-037 OPERAND=20, OPCLEAR in cycle 40 -> IDLE next cycle, OPDONE=0; a later write of OPERAND=4 with MODE=0 -> RESULT_L=24.
